// File: rtl/imem_loader.sv
// Byte-stream program loader: parses SYNC/addr/count/data/checksum frames and
// writes little-endian 32-bit words into the instruction memory.
module imem_loader #(
    parameter int ADDR_W = 10,  // header fields are 16 bits, so ADDR_W must stay <= 14
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              fetch_hold,
    output logic              done,
    output logic              err,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR0, S_ADDR1, S_CNT0, S_CNT1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_e;

    localparam logic [7:0]        SYNC  = 8'hA5;
    localparam logic [ADDR_W+1:0] DEPTH = {2'b01, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [15:0]         addr_q, addr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [7:0]          csum_q, csum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                accept;
    logic [15:0]         n_full;
    logic [ADDR_W+1:0]   end_sum;
    logic                hdr_bad;

    assign in_ready   = (state_q != S_DONE) && (state_q != S_ERR);
    assign accept     = in_valid && in_ready;
    assign fetch_hold = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign dbg_state  = state_q;
    assign mem_we     = we_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = wdata_q;

    // The end-of-block sum is two bits wider than the address so a block that
    // runs past the top of memory can never wrap back into range.
    assign n_full  = {in_data, cnt_q[7:0]};
    assign end_sum = {2'b00, addr_q[ADDR_W-1:0]} + {1'b0, n_full[ADDR_W:0]};
    assign hdr_bad = (|addr_q[15:ADDR_W]) || (n_full == 16'd0) ||
                     (|n_full[15:ADDR_W+1]) || (end_sum > DEPTH);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept && in_data == SYNC) begin
                    state_d = S_ADDR0;
                    bcnt_d  = 2'd0;
                    word_d  = '0;
                    csum_d  = 8'h00;
                end
            end
            S_ADDR0: if (accept) begin
                addr_d[7:0] = in_data;
                state_d     = S_ADDR1;
            end
            S_ADDR1: if (accept) begin
                addr_d[15:8] = in_data;
                state_d      = S_CNT0;
            end
            S_CNT0: if (accept) begin
                cnt_d[7:0] = in_data;
                state_d    = S_CNT1;
            end
            S_CNT1: if (accept) begin
                cnt_d   = n_full;
                state_d = hdr_bad ? S_ERR : S_DATA;
            end
            S_DATA: if (accept) begin
                word_d[{bcnt_q, 3'b000} +: 8] = in_data;
                csum_d = csum_q ^ in_data;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    we_d    = 1'b1;
                    maddr_d = addr_q[ADDR_W-1:0];
                    wdata_d = {in_data, word_q[23:0]};
                    addr_d  = addr_q + 16'd1;
                    cnt_d   = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: if (accept) begin
                state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: drivers push expected writes/events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_imem_loader;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              fetch_hold;
    logic              done;
    logic              err;
    logic [3:0]        dbg_state;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .fetch_hold(fetch_hold), .done(done),
        .err(err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [41:0] exp_q[$];     // {addr, data}
    logic [1:0]  exp_ev_q[$];  // {done, err}
    int          wr_cyc_q[$];
    int          acc_q[$];
    int          ev_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                         mem_addr, mem_wdata);
            end else begin
                check("write", {22'b0, mem_addr, mem_wdata}, {22'b0, exp_q.pop_front()});
            end
        end
        if (done === 1'b1 || err === 1'b1) begin
            ev_cyc = cyc;
            if (exp_ev_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got done=%0b err=%0b, none expected", done, err);
            end else begin
                check("event", {62'b0, done, err}, {62'b0, exp_ev_q.pop_front()});
            end
        end
    end

    // drivers
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got in_ready=0 for 20 cycles, required 1");
        end
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input bit gaps);
        int last;
        acc_q.delete();
        wr_cyc_q.delete();
        foreach (fr[i]) begin
            send_byte(fr[i], gaps);
            check("fetch_hold_in_frame", {63'b0, fetch_hold}, 64'd1);
        end
        last = acc_q[acc_q.size()-1];
        @(posedge clk);
        #1;
        check("event_cycle", ev_cyc, last);
        check("pulse_end", {62'b0, done, err}, 64'd0);
        check("fetch_hold_after", {63'b0, fetch_hold}, 64'd0);
        check("ready_after", {63'b0, in_ready}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   {63'b0, in_ready},   64'd1);
        check({tag, "_mem_we"},     {63'b0, mem_we},     64'd0);
        check({tag, "_mem_addr"},   {54'b0, mem_addr},   64'd0);
        check({tag, "_mem_wdata"},  {32'b0, mem_wdata},  64'd0);
        check({tag, "_fetch_hold"}, {63'b0, fetch_hold}, 64'd0);
        check({tag, "_done_err"},   {62'b0, done, err},  64'd0);
    endtask

    logic [7:0] f[$];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single word at 0x010
        exp_q.push_back({10'h010, 32'h12345678});
        exp_ev_q.push_back(2'b10);
        f = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_frame(f, 1'b0);
        check("single_nwr", wr_cyc_q.size(), 64'd1);
        if (wr_cyc_q.size() >= 1) check("single_wr_cycle", wr_cyc_q[0], acc_q[8]);
        check("single_wdata_hold", {32'b0, mem_wdata}, 64'h12345678);

        // three-word burst ending at the last legal word, 0xA5 inside data
        exp_q.push_back({10'h3FD, 32'h11223344});
        exp_q.push_back({10'h3FE, 32'h55667788});
        exp_q.push_back({10'h3FF, 32'hA5A5A5A5});
        exp_ev_q.push_back(2'b10);
        f = '{8'hA5, 8'hFD, 8'h03, 8'h03, 8'h00,
              8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
              8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h88};
        send_frame(f, 1'b0);
        check("burst_nwr", wr_cyc_q.size(), 64'd3);
        if (wr_cyc_q.size() == 3) begin
            check("burst_wr0_cycle", wr_cyc_q[0], acc_q[8]);
            check("burst_gap01", wr_cyc_q[1] - wr_cyc_q[0], 64'd4);
            check("burst_gap12", wr_cyc_q[2] - wr_cyc_q[1], 64'd4);
        end

        // header range errors
        exp_ev_q.push_back(2'b01);
        f = '{8'hA5, 8'hFF, 8'h03, 8'h02, 8'h00};
        send_frame(f, 1'b0);
        check("err_overrun_nwr", wr_cyc_q.size(), 64'd0);

        exp_ev_q.push_back(2'b01);
        f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(f, 1'b0);
        check("err_zero_cnt_nwr", wr_cyc_q.size(), 64'd0);

        exp_ev_q.push_back(2'b01);
        f = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h00};
        send_frame(f, 1'b0);
        check("err_addr_nwr", wr_cyc_q.size(), 64'd0);

        // bad checksum: writes land, then err
        exp_q.push_back({10'h020, 32'hDEADBEEF});
        exp_q.push_back({10'h021, 32'h01020304});
        exp_ev_q.push_back(2'b01);
        f = '{8'hA5, 8'h20, 8'h00, 8'h02, 8'h00,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01, 8'h27};
        send_frame(f, 1'b0);
        check("badcsum_nwr", wr_cyc_q.size(), 64'd2);

        // garbage before SYNC, random stalls mid-frame
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        check("garbage_no_hold", {63'b0, fetch_hold}, 64'd0);
        exp_q.push_back({10'h020, 32'hDEADBEEF});
        exp_q.push_back({10'h021, 32'h01020304});
        exp_ev_q.push_back(2'b10);
        f = '{8'hA5, 8'h20, 8'h00, 8'h02, 8'h00,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01, 8'h26};
        send_frame(f, 1'b1);
        check("gaps_nwr", wr_cyc_q.size(), 64'd2);

        // reset after the second data byte
        wr_cyc_q.delete();
        f = '{8'hA5, 8'h40, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
        foreach (f[i]) send_byte(f[i], 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_nwr", wr_cyc_q.size(), 64'd0);

        exp_q.push_back({10'h040, 32'hCAFEF00D});
        exp_ev_q.push_back(2'b10);
        f = '{8'hA5, 8'h40, 8'h00, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hC9};
        send_frame(f, 1'b0);
        check("after_reset_nwr", wr_cyc_q.size(), 64'd1);

        repeat (5) @(posedge clk);
        #1;
        check("exp_writes_drained", exp_q.size(), 64'd0);
        check("exp_events_drained", exp_ev_q.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory read by the fetch stage. Accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and issues one write per word into the 1024-word instruction memory. Holds the fetch stage for the whole frame and reports completion or error.

## Interface

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2^ADDR_W words.
- DATA_W, 32, instruction word width; fixed at 32, so four bytes per word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready; a byte is accepted on a rising edge with in_valid && in_ready.
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  out  ADDR_W  word write address.
- mem_wdata  out  32  word write data.
- fetch_hold  out  1  high while a frame is in progress; the fetch stage must not advance PC.
- done  out  1  one-cycle pulse when a frame completes with a good checksum.
- err  out  1  one-cycle pulse on a frame error.

## Operation

- Frame layout, in byte order:
  - SYNC 0xA5.
  - ADDR_LO, ADDR_HI: start word address, little-endian.
  - CNT_LO, CNT_HI: word count N, little-endian.
  - 4N data bytes: each word little-endian, lowest byte first.
  - CSUM: XOR of all 4N data bytes.
- States: IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA, CSUM, DONE, ERR.
- IDLE:
  - Bytes other than 0xA5 are accepted and discarded.
  - 0xA5 moves to ADDR0.
- ADDR0/ADDR1, CNT0/CNT1: capture one header byte each.
- Header check, evaluated on acceptance of CNT_HI:
  - Error if the address is ≥ 2^ADDR_W, N == 0, or start + N > 2^ADDR_W. An error goes to ERR.
  - Otherwise go to DATA.
- Width rule: the start + N check uses ADDR_W+2 bits, so wrap-around never passes the check.
- DATA:
  - A 2-bit byte counter shifts each byte into a word assembly register; bytes are placed at bits [8k+7:8k].
  - The running checksum XORs every data byte.
  - On the 4th byte: issue a write, increment the address, decrement the remaining count.
  - After the last word, go to CSUM.
- CSUM:
  - Received byte equal to the running XOR goes to DONE; otherwise go to ERR.
  - Words already written are not rolled back.
- DONE and ERR last one cycle each, then return to IDLE.
- in_ready is 1 in every state except DONE and ERR.
- fetch_hold is 1 from the cycle after SYNC is accepted through the DONE/ERR cycle inclusive.

## Timing

- Reset values: in_ready = 1 (state IDLE); mem_we = 0, mem_addr = 0, mem_wdata = 0, fetch_hold = 0, done = 0, err = 0. Checksum, counters and the assembly register are all cleared.
- Reset asserted mid-frame: immediate return to IDLE with all of the above values; no further write occurs.
- mem_we, mem_addr and mem_wdata are registered:
  - Valid in the cycle after the edge that accepted the 4th byte of a word.
  - mem_we is high for exactly one cycle.
  - mem_addr and mem_wdata hold their values until the next write.
- Throughput: one byte per cycle; back-to-back words give mem_we every 4th cycle.
- done/err: asserted in the cycle after the edge that accepted CSUM (or CNT_HI, for a header error). That is the same cycle as the DONE/ERR state.
- in_valid low stalls any state with no state change. Counters and partial words are retained.
- A 0xA5 byte inside header, data or CSUM is ordinary data, never a resync.

## Test plan

- Single word: A5 10 00 01 00 78 56 34 12 CSUM=0x08 → one mem_we, mem_addr=0x010, mem_wdata=0x12345678; done pulse one cycle after CSUM; fetch_hold high SYNC+1 through DONE.
- Burst of 3 words at address 0x3FD (last legal block): three writes to 0x3FD, 0x3FE, 0x3FF, each 4 cycles apart with in_valid held high; done = 1.
- Range errors:
  - Address 0x3FF with N = 2 → err pulse after CNT_HI, no mem_we, return to IDLE.
  - N = 0 → err pulse after CNT_HI, no mem_we, return to IDLE.
  - Address 0x0400 → err pulse after CNT_HI, no mem_we, return to IDLE.
- Bad checksum on 2 words → both writes occur, then err (not done); fetch_hold drops the cycle after ERR.
- Garbage 0x00 0xFF before SYNC, and in_valid toggled randomly mid-data → garbage ignored; written words identical to the gap-free case.
- rst_n pulled low after the 2nd data byte → all outputs at reset values immediately, no write. A following clean frame loads correctly.
